// File: rtl/mrv1_fu_dispatch.sv
// mrv1_fu_dispatch
//   Round-robin arbiter feeding a single-entry issue slot that dispatches one
//   request per cycle to one of five functional units (INT, MEM, MUL, SYS, DIV).
//   Requests whose FU type is 5..7 are accepted, dropped and reported with a
//   one-cycle illegal pulse.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         empties the slot, blocks accept this cycle
//   req_valid_i     per-requester valid        [NUM_REQ]
//   req_fu_type_i   per-requester FU type      [NUM_REQ*3]
//   req_op_i        per-requester opcode       [NUM_REQ*OP_WIDTH]
//   req_ready_o     one-hot grant              [NUM_REQ]
//   fu_valid_o      one-hot issue valid, bit = FU type [5]
//   fu_op_o         issued opcode
//   fu_src_o        issuing requester index
//   fu_ready_i      per-FU ready, bit = FU type [5]
//   illegal_o       pulse: illegal type accepted and dropped
//   illegal_src_o   requester index of the dropped request
module mrv1_fu_dispatch #(
    parameter int NUM_REQ  = 4,
    parameter int OP_WIDTH = 7
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*3-1:0]         req_fu_type_i,
    input  logic [NUM_REQ*OP_WIDTH-1:0]  req_op_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic [4:0]                   fu_valid_o,
    output logic [OP_WIDTH-1:0]          fu_op_o,
    output logic [$clog2(NUM_REQ)-1:0]   fu_src_o,
    input  logic [4:0]                   fu_ready_i,
    output logic                         illegal_o,
    output logic [$clog2(NUM_REQ)-1:0]   illegal_src_o
);

    localparam int SRC_W = $clog2(NUM_REQ);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state_q, state_d;
    logic [2:0]           type_q;
    logic [OP_WIDTH-1:0]  op_q;
    logic [SRC_W-1:0]     src_q;
    logic [SRC_W-1:0]     ptr_q;
    logic                 illegal_q;
    logic [SRC_W-1:0]     illegal_src_q;

    logic [SRC_W-1:0]     win;
    logic                 any;
    int                   idx;
    logic [2:0]           win_type;
    logic [OP_WIDTH-1:0]  win_op;
    logic                 drain, can_acc, accept, legal;

    // Round-robin search starting at ptr_q, wrapping at NUM_REQ-1.
    always_comb begin
        any = 1'b0;
        win = '0;
        idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any && req_valid_i[idx]) begin
                any = 1'b1;
                win = SRC_W'(idx);
            end
        end
    end

    assign win_type = req_fu_type_i[int'(win)*3 +: 3];
    assign win_op   = req_op_i[int'(win)*OP_WIDTH +: OP_WIDTH];
    assign legal    = (win_type <= 3'd4);

    assign fu_valid_o = (state_q == FULL) ? (5'b00001 << type_q) : 5'b00000;
    // Only the target FU's ready bit matters, since fu_valid_o is one-hot.
    assign drain      = |(fu_valid_o & fu_ready_i);
    // rst_ni gates the grant so nothing is handshaken while reset is held.
    assign can_acc    = rst_ni && !flush_i && ((state_q == EMPTY) || drain);
    assign accept     = can_acc && any;

    assign req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        state_d = state_q;
        if (flush_i)               state_d = EMPTY;
        else if (accept && legal)  state_d = FULL;
        else if (drain)            state_d = EMPTY;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= EMPTY;
            type_q        <= '0;
            op_q          <= '0;
            src_q         <= '0;
            ptr_q         <= '0;
            illegal_q     <= 1'b0;
            illegal_src_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= accept && !legal;
            if (accept && legal) begin
                type_q <= win_type;
                op_q   <= win_op;
                src_q  <= win;
            end
            if (accept && !legal) illegal_src_q <= win;
            if (accept) ptr_q <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    // Slot payload registers only change on load, so they hold while EMPTY.
    assign fu_op_o       = op_q;
    assign fu_src_o      = src_q;
    assign illegal_o     = illegal_q;
    assign illegal_src_o = illegal_src_q;

endmodule

// File: doc/mrv1_fu_dispatch.md
MRV1_FU_DISPATCH -- requirements
Module: mrv1_fu_dispatch

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter OP_WIDTH, default 7, FU opcode width.
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 SHALL have port clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have port flush_i  in  1  synchronous flush of the issue slot.
REQ-007 SHALL have port req_valid_i  in  NUM_REQ  per-requester request valid.
REQ-008 SHALL have port req_fu_type_i  in  NUM_REQ*3  per-requester FU type (INT=0, MEM=1, MUL=2, SYS=3, DIV=4).
REQ-009 SHALL have port req_op_i  in  NUM_REQ*OP_WIDTH  per-requester FU opcode.
REQ-010 SHALL have port req_ready_o  out  NUM_REQ  one-hot grant/accept.
REQ-011 SHALL have port fu_valid_o  out  5  one-hot issue valid, bit index = FU type.
REQ-012 SHALL have port fu_op_o  out  OP_WIDTH  opcode of the issued request.
REQ-013 SHALL have port fu_src_o  out  $clog2(NUM_REQ)  index of the issuing requester.
REQ-014 SHALL have port fu_ready_i  in  5  per-FU ready, bit index = FU type.
REQ-015 SHALL have port illegal_o  out  1  one-cycle pulse: FU type 5..7 was accepted and dropped.
REQ-016 SHALL have port illegal_src_o  out  $clog2(NUM_REQ)  requester index of the dropped request.

Function
REQ-017 SHALL hold a single-entry issue slot with two states, EMPTY and FULL.
REQ-018 SHALL allow the slot to accept when EMPTY, or when FULL and fu_valid_o & fu_ready_i is nonzero in the same cycle.
REQ-019 SHALL pick the winner by round-robin over req_valid_i, searching from pointer ptr upward and wrapping at NUM_REQ-1 to 0.
REQ-020 SHALL, when it may accept, assert req_ready_o combinationally on the winner bit only; all other bits stay 0.
REQ-021 SHALL, on an accepted legal type, load the slot in the same edge and drive fu_valid_o, fu_op_o and fu_src_o from the next cycle (latency 1).
REQ-022 SHALL, on an accepted illegal type (5..7), leave the slot unchanged and pulse illegal_o and illegal_src_o in the next cycle.
REQ-023 SHALL set ptr to (winner+1) mod NUM_REQ on every accept, legal or illegal; otherwise ptr holds.
REQ-024 SHALL keep fu_valid_o, fu_op_o and fu_src_o stable while FULL and the target fu_ready_i bit is 0.
REQ-025 SHALL ignore fu_ready_i bits other than the target FU.
REQ-026 SHALL sustain one issue per cycle when the target FU ready bits stay high (back-to-back: drain and load in the same edge).
REQ-027 SHALL go to EMPTY when FULL, the target accepts, and no request is granted.
REQ-028 SHALL, on flush_i=1, force the slot to EMPTY, deassert all req_ready_o and suppress illegal_o for that cycle; flush takes priority over accept and drain; ptr holds.
REQ-029 SHALL drive fu_valid_o=0 whenever EMPTY; fu_op_o and fu_src_o are then don't-care but SHALL NOT toggle.
REQ-030 SHALL tolerate req_valid_i deassertion without grant; there is no request-side holding requirement.

Reset
REQ-031 SHALL, while rst_ni=0, hold: slot EMPTY, ptr=0, fu_valid_o=0, fu_op_o=0, fu_src_o=0, illegal_o=0, illegal_src_o=0.
REQ-032 SHALL hold req_ready_o=0 while rst_ni=0.
REQ-033 SHALL discard an occupied slot if reset asserts mid-operation, with no issue after release.
REQ-034 SHALL grant normally in the first cycle after reset release.

Verification
REQ-035 SHALL test single issue: req 2 valid with type INT, op 0x18, fu_ready_i=5'b11111 -> req_ready_o=4'b0100; next cycle fu_valid_o=5'b00001, fu_op_o=0x18, fu_src_o=2.
REQ-036 SHALL test round robin: all 4 valid with type MUL and fu_ready_i high -> grants 0,1,2,3,0 on consecutive cycles and fu_valid_o=5'b00100 each cycle.
REQ-037 SHALL test backpressure: req 1 with type DIV, fu_ready_i[4]=0 for 3 cycles -> fu_valid_o=5'b10000 and op stable for 3 cycles, req_ready_o=0 throughout, slot drains on the cycle fu_ready_i[4]=1.
REQ-038 SHALL test illegal type: req 3 with type 6 -> req_ready_o[3]=1, next cycle illegal_o=1, illegal_src_o=3, fu_valid_o=0, ptr=0.
REQ-039 SHALL test flush vs accept: slot FULL, flush_i=1 with req 0 valid -> req_ready_o=0, next cycle fu_valid_o=0; ptr unchanged.
REQ-040 SHALL test reset mid-operation: slot FULL with fu_ready_i=0, pulse rst_ni low -> fu_valid_o=0 immediately (asynchronous), then first grant after release goes to req 0.
